// File: rtl/race_snapshot_capture.sv
// ============================================================================
// Module   : race_snapshot_capture
// Brief    : Synchronises a {w,x,y,z} observation bus, waits for SETTLE equal
//            samples and queues each settled value once in a valid/ready FIFO.
//            Optional per-entry timestamps: define RACE_SNAPSHOT_TS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module race_snapshot_capture #(
    parameter int SYNC_STAGES = 2,
    parameter int SETTLE      = 3,
    parameter int DEPTH       = 4,
    parameter int TS_W        = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     w,
    input  logic                     x,
    input  logic                     y,
    input  logic                     z,
    input  logic                     arm,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [3:0]               out_data,
`ifdef RACE_SNAPSHOT_TS_EN
    output logic [TS_W-1:0]          out_ts,
`endif
    output logic                     settled,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int FCNT_W = PTR_W + 1;
    localparam int CNT_W  = (SETTLE > 1) ? $clog2(SETTLE) : 1;
`ifdef RACE_SNAPSHOT_TS_EN
    localparam int ENTRY_W = 4 + TS_W;
`else
    localparam int ENTRY_W = 4;
`endif
    localparam logic [CNT_W-1:0]  C_CNT_LAST = CNT_W'(SETTLE - 1);
    localparam logic [FCNT_W-1:0] C_FULL     = FCNT_W'(DEPTH);

    if (SYNC_STAGES < 2 || SETTLE < 1 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TS_W < 1)
    begin : g_param_check
        $error("race_snapshot_capture: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_SETTLING = 2'd1,
        S_STABLE   = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0][3:0] sync_chain_q;
    logic [3:0]                  sync_q;
    logic [3:0]                  prev_q;
    state_t                      state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic                        push;

    assign sync_q = sync_chain_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_chain_q <= '0;
            prev_q       <= '0;
            state_q      <= S_IDLE;
            cnt_q        <= '0;
        end else begin
            sync_chain_q <= {sync_chain_q[SYNC_STAGES-2:0], {w, x, y, z}};
            prev_q       <= sync_q;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
        end
    end

    // arm has priority over every state transition
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        push    = 1'b0;
        if (!arm) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_SETTLING;
                    cnt_d   = '0;
                end
                S_SETTLING: begin
                    if (sync_q != prev_q) begin
                        cnt_d = '0;
                    end else if (cnt_q == C_CNT_LAST) begin
                        push    = 1'b1;
                        state_d = S_STABLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_STABLE: begin
                    if (sync_q != prev_q) begin
                        state_d = S_SETTLING;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign settled = (state_q == S_STABLE);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [FCNT_W-1:0]  count_q;
    logic               overflow_q;
    logic               full, pop, push_ok;
    logic [ENTRY_W-1:0] entry_in;
    logic [ENTRY_W-1:0] head;

`ifdef RACE_SNAPSHOT_TS_EN
    logic [TS_W-1:0] ts_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + 1'b1;
        end
    end

    assign entry_in = {ts_q, sync_q};
    assign out_ts   = head[ENTRY_W-1:4];
`else
    assign entry_in = sync_q;
`endif

    assign full      = (count_q == C_FULL);
    assign out_valid = (count_q != '0);
    assign pop       = out_valid && out_ready;
    // A pop on the same edge frees the slot a full-FIFO push needs
    assign push_ok   = push && (!full || pop);
    assign head      = out_valid ? mem_q[rd_ptr_q] : '0;
    assign out_data  = head[3:0];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= entry_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push_ok && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (!push_ok && pop) begin
                count_q <= count_q - 1'b1;
            end
            if (push && full && !pop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign overflow   = overflow_q;
    assign fifo_count = count_q;

endmodule

`default_nettype wire

// File: tb/tb_race_snapshot_capture.sv
// Directed stimulus with a queue scoreboard; a negedge monitor checks every popped entry.
`default_nettype none

module tb_race_snapshot_capture;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       w, x, y, z;
    logic       arm;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic       settled;
    logic       overflow;
    logic [2:0] fifo_count;
`ifdef RACE_SNAPSHOT_TS_EN
    logic [7:0] out_ts;
`endif

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_q[$];

    race_snapshot_capture #(
        .SYNC_STAGES(2),
        .SETTLE     (3),
        .DEPTH      (4),
        .TS_W       (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .w         (w),
        .x         (x),
        .y         (y),
        .z         (z),
        .arm       (arm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
`ifdef RACE_SNAPSHOT_TS_EN
        .out_ts    (out_ts),
`endif
        .settled   (settled),
        .overflow  (overflow),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [3:0] v);
        {w, x, y, z} = v;
    endtask

    // Monitor: an entry presented with ready high is consumed at the next edge
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected: got %0h expected none", out_data);
            end else begin
                logic [3:0] e;
                e = exp_q.pop_front();
                if (out_data !== e) begin
                    errors++;
                    $display("FAIL pop_data: got %0h expected %0h", out_data, e);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        arm = 1'b0;
        out_ready = 1'b0;
        set_in(4'b0110);
        tick(3);
        chk("rst_valid", out_valid, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_settled", settled, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_data", out_data, 0);

        rst_n = 1'b1;
        tick(4);
        arm = 1'b1;
        tick(3);
        chk("lat_settled_early", settled, 0);
        chk("lat_count_early", fifo_count, 0);
        tick(1);
        exp_q.push_back(4'b0110);
        chk("lat_settled", settled, 1);
        chk("lat_valid", out_valid, 1);
        chk("lat_data", out_data, 4'b0110);
        chk("lat_count", fifo_count, 1);

        // Short glitch to 0111 while stable: only the resettled 0110 is captured
        set_in(4'b0111);
        tick(2);
        set_in(4'b0110);
        tick(12);
        exp_q.push_back(4'b0110);
        chk("glitch_count", fifo_count, 2);
        chk("glitch_settled", settled, 1);
        out_ready = 1'b1;
        tick(3);
        out_ready = 1'b0;
        chk("glitch_drained", fifo_count, 0);

        // Five settled values into a 4-deep FIFO with no consumer
        for (int i = 1; i <= 5; i++) begin
            set_in(4'(i));
            if (i <= 4) exp_q.push_back(4'(i));
            tick(10);
        end
        chk("ovf_count", fifo_count, 4);
        chk("ovf_flag", overflow, 1);
        chk("ovf_head", out_data, 4'b0001);
        out_ready = 1'b1;
        tick(6);
        out_ready = 1'b0;
        chk("ovf_drained", fifo_count, 0);
        chk("ovf_sticky", overflow, 1);

        // Two entries held, reset while SETTLING
        set_in(4'b1010);
        tick(10);
        set_in(4'b1011);
        tick(10);
        chk("pre_rst_count", fifo_count, 2);
        set_in(4'b1100);
        tick(4);
        rst_n = 1'b0;
        arm = 1'b0;
        tick(1);
        rst_n = 1'b1;
        exp_q.delete();
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_count", fifo_count, 0);
        chk("mid_rst_settled", settled, 0);
        chk("mid_rst_overflow", overflow, 0);
        tick(4);
        arm = 1'b1;
        tick(6);
        exp_q.push_back(4'b1100);
        chk("rearm_count", fifo_count, 1);

        // Fill, then push and pop on the same edge while full
        for (int i = 13; i <= 15; i++) begin
            set_in(4'(i));
            exp_q.push_back(4'(i));
            tick(10);
        end
        chk("full_count", fifo_count, 4);
        chk("full_overflow", overflow, 0);
        set_in(4'b0000);
        exp_q.push_back(4'b0000);
        tick(5);
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        chk("pushpop_count", fifo_count, 4);
        chk("pushpop_overflow", overflow, 0);
        chk("pushpop_head", out_data, 4'b1101);
        out_ready = 1'b1;
        tick(6);
        out_ready = 1'b0;
        chk("final_count", fifo_count, 0);
        chk("final_scoreboard_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
